// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, parity types and legal prescale ratios
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic {PAR_EVEN = 1'b0, PAR_ODD = 1'b1} par_typ_t;
  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;
endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line, frame configuration and received-byte outputs
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Par_Err;
  logic                  Stp_Err;
  modport master (output RX_IN, Prescale, PAR_EN, PAR_TYP, input P_DATA, Data_Valid, Par_Err, Stp_Err);
  modport slave  (input RX_IN, Prescale, PAR_EN, PAR_TYP, output P_DATA, Data_Valid, Par_Err, Stp_Err);
endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter with 3-sample majority vote around mid-bit
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rx_s,
  input  logic                  i_run,
  input  logic [PRESCALE_W-1:0] i_presc,
  output logic                  o_bit_done,
  output logic                  o_dec,
  output logic                  o_bit_val
);
  logic [PRESCALE_W-1:0] r_edge, w_half;
  logic [1:0]            r_smp;
  logic                  r_val, r_dec;
  assign w_half     = i_presc >> 1;
  assign o_bit_done = i_run && r_edge == i_presc - PRESCALE_W'(1);
  assign o_dec      = r_dec;
  assign o_bit_val  = r_val;
  // third sample is taken live and voted in the same cycle; o_dec marks the registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge <= '0;
      r_smp  <= 2'b11;
      r_val  <= 1'b1;
      r_dec  <= 1'b0;
    end else begin
      r_edge <= (!i_run || o_bit_done) ? '0 : r_edge + PRESCALE_W'(1);
      if (r_edge == w_half - PRESCALE_W'(1)) r_smp[0] <= i_rx_s;
      if (r_edge == w_half) r_smp[1] <= i_rx_s;
      if (r_edge == w_half + PRESCALE_W'(1)) r_val <= (r_smp[0] & r_smp[1]) | (r_smp[0] & i_rx_s) | (r_smp[1] & i_rx_s);
      r_dec <= i_run && r_edge == w_half + PRESCALE_W'(1);
    end
  end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver with start-glitch rejection, optional parity and stop check
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_frame_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  logic [1:0]            r_sync;
  rx_state_t             r_state, w_next;
  logic [PRESCALE_W-1:0] r_presc, w_presc;
  logic                  r_par_en;
  par_typ_t              r_par_typ;
  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift, r_data;
  logic                  r_par_bad, r_dv, r_pe, r_se;
  logic                  w_rx_s, w_bit_done, w_dec, w_bit_val, w_launch, w_finish, w_par_exp;
  assign w_rx_s    = r_sync[1];
  assign w_presc   = (bus.Prescale == PRESCALE_W'(PRESC_16) || bus.Prescale == PRESCALE_W'(PRESC_32)) ? bus.Prescale : PRESCALE_W'(PRESC_8);
  assign w_launch  = r_state == IDLE && !w_rx_s;
  assign w_finish  = r_state == STOP && w_dec;
  assign w_par_exp = r_par_typ == PAR_ODD ? ~^r_shift : ^r_shift;
  assign bus.P_DATA     = r_data;
  assign bus.Data_Valid = r_dv;
  assign bus.Par_Err    = r_pe;
  assign bus.Stp_Err    = r_se;
  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .clk        (CLK),
    .rst        (RST),
    .i_rx_s     (w_rx_s),
    .i_run      (r_state != IDLE),
    .i_presc    (r_presc),
    .o_bit_done (w_bit_done),
    .o_dec      (w_dec),
    .o_bit_val  (w_bit_val)
  );
  // STOP leaves at the decision, not the bit end, so a back-to-back start edge is not missed
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_rx_s ? IDLE : START;
      START:   w_next = (w_dec && w_bit_val) ? IDLE : w_bit_done ? DATA : START;
      DATA:    w_next = (w_bit_done && r_bit_cnt == LAST) ? (r_par_en ? PARITY : STOP) : DATA;
      PARITY:  w_next = w_bit_done ? STOP : PARITY;
      STOP:    w_next = w_dec ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync    <= 2'b11;
      r_state   <= IDLE;
      r_presc   <= PRESCALE_W'(PRESC_8);
      r_par_en  <= 1'b0;
      r_par_typ <= PAR_EVEN;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bad <= 1'b0;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_pe      <= 1'b0;
      r_se      <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], bus.RX_IN};
      r_state <= w_next;
      r_dv    <= w_finish && w_bit_val && !r_par_bad;
      r_pe    <= w_finish && r_par_bad;
      r_se    <= w_finish && !w_bit_val;
      if (w_launch) begin
        r_presc   <= w_presc;
        r_par_en  <= bus.PAR_EN;
        r_par_typ <= par_typ_t'(bus.PAR_TYP);
        r_bit_cnt <= '0;
        r_par_bad <= 1'b0;
      end
      if (r_state == DATA && w_dec) r_shift[r_bit_cnt] <= w_bit_val;
      if (r_state == DATA && w_bit_done) r_bit_cnt <= r_bit_cnt == LAST ? '0 : r_bit_cnt + CW'(1);
      if (r_state == PARITY && w_dec) r_par_bad <= w_bit_val != w_par_exp;
      if (w_finish && w_bit_val && !r_par_bad) r_data <= r_shift;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames with hand-computed expected bytes and error pulses
module tb_uart_rx_frame;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  uart_rx_frame_if bus ();
  uart_rx_frame dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  int checks = 0;
  int failures = 0;
  int pe_n = 0;
  int se_n = 0;
  logic [7:0] dv_q[$];
  logic dv_prev = 1'b0;
  logic [7:0] b2b[4] = '{8'hCC, 8'h10, 8'h0E, 8'h05};
  always @(negedge CLK) begin
    if (bus.Data_Valid === 1'b1) begin
      checks++;
      assert (dv_prev === 1'b0) else begin
        failures++;
        $error("FAIL dv_width: Data_Valid high %0d cycles in a row, expected 1", 2);
      end
      dv_q.push_back(bus.P_DATA);
    end
    if (bus.Par_Err === 1'b1) pe_n++;
    if (bus.Stp_Err === 1'b1) se_n++;
    dv_prev = bus.Data_Valid;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] qat(input int i);
    return i < dv_q.size() ? dv_q[i] : 8'hxx;
  endfunction
  task automatic clr();
    dv_q.delete();
    pe_n = 0;
    se_n = 0;
  endtask
  task automatic idle(input int n);
    bus.RX_IN = 1'b1;
    repeat (n) @(negedge CLK);
  endtask
  task automatic send_bit(input logic b, input int n);
    bus.RX_IN = b;
    repeat (n) @(negedge CLK);
  endtask
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic ptyp,
                            input logic pflip, input logic stop);
    send_bit(1'b0, p);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pen) send_bit((ptyp ? ~^d : ^d) ^ pflip, p);
    send_bit(stop, p);
  endtask
  initial begin
    bus.RX_IN = 1'b1;
    bus.Prescale = 6'd8;
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_pdata", 32'(bus.P_DATA), 32'h0);
    chk("rst_dv", 32'(bus.Data_Valid), 32'h0);
    chk("rst_pe", 32'(bus.Par_Err), 32'h0);
    chk("rst_se", 32'(bus.Stp_Err), 32'h0);
    RST = 1'b0;
    idle(4);
    clr();
    send_frame(8'hCC, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(16);
    chk("t1_cnt", 32'(dv_q.size()), 32'd1);
    chk("t1_data", 32'(qat(0)), 32'hCC);
    chk("t1_pe", 32'(pe_n), 32'd0);
    chk("t1_se", 32'(se_n), 32'd0);
    clr();
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 8, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(16);
    chk("t2_cnt", 32'(dv_q.size()), 32'd4);
    chk("t2_d0", 32'(qat(0)), 32'hCC);
    chk("t2_d1", 32'(qat(1)), 32'h10);
    chk("t2_d2", 32'(qat(2)), 32'h0E);
    chk("t2_d3", 32'(qat(3)), 32'h05);
    chk("t2_err", 32'(pe_n + se_n), 32'd0);
    clr();
    send_frame(8'h09, 8, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(16);
    chk("t3_pe", 32'(pe_n), 32'd1);
    chk("t3_cnt", 32'(dv_q.size()), 32'd0);
    chk("t3_hold", 32'(bus.P_DATA), 32'h05);
    chk("t3_se", 32'(se_n), 32'd0);
    clr();
    send_frame(8'hAA, 8, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(24);
    chk("t4_se", 32'(se_n), 32'd1);
    chk("t4_cnt", 32'(dv_q.size()), 32'd0);
    chk("t4_pe", 32'(pe_n), 32'd0);
    clr();
    send_frame(8'hBB, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(16);
    chk("t4b_cnt", 32'(dv_q.size()), 32'd1);
    chk("t4b_data", 32'(qat(0)), 32'hBB);
    chk("t4b_err", 32'(pe_n + se_n), 32'd0);
    clr();
    send_bit(1'b0, 3);
    idle(16);
    chk("t5_glitch_dv", 32'(dv_q.size()), 32'd0);
    chk("t5_glitch_pe", 32'(pe_n), 32'd0);
    chk("t5_glitch_se", 32'(se_n), 32'd0);
    bus.Prescale = 6'd32;
    bus.PAR_EN = 1'b0;
    send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(64);
    chk("t5_cnt", 32'(dv_q.size()), 32'd1);
    chk("t5_data", 32'(qat(0)), 32'h5A);
    chk("t5_err", 32'(pe_n + se_n), 32'd0);
    bus.Prescale = 6'd8;
    bus.PAR_EN = 1'b1;
    clr();
    send_bit(1'b0, 8);
    send_bit(1'b0, 8);
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b1, 8);
    RST = 1'b1;
    #1;
    chk("t6_rst_pdata", 32'(bus.P_DATA), 32'h0);
    chk("t6_rst_dv", 32'(bus.Data_Valid), 32'h0);
    chk("t6_rst_pe", 32'(bus.Par_Err), 32'h0);
    chk("t6_rst_se", 32'(bus.Stp_Err), 32'h0);
    idle(5);
    RST = 1'b0;
    idle(16);
    send_frame(8'h81, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(16);
    chk("t6_cnt", 32'(dv_q.size()), 32'd1);
    chk("t6_data", 32'(qat(0)), 32'h81);
    chk("t6_err", 32'(pe_n + se_n), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
